// File: rtl/shift_pkg.sv
// shift_pkg: shared constants for the pipelined right shifter.
//   - Operation encoding for in_op (SRL/SRA/SRLW/SRAW).
//   - Datapath widths.
//   - Per-stage shift strides (16/4/1) and the shamt bit slice each stage consumes.
//   - Small decode helpers for the op field.
package shift_pkg;

    localparam logic [1:0] SHOP_SRL  = 2'b00;
    localparam logic [1:0] SHOP_SRA  = 2'b01;
    localparam logic [1:0] SHOP_SRLW = 2'b10;
    localparam logic [1:0] SHOP_SRAW = 2'b11;

    localparam int XLEN    = 64;
    localparam int SHAMT_W = 6;

    // Radix-4 decomposition: each stage consumes two shamt bits.
    localparam int STRIDE_S1 = 16;
    localparam int STRIDE_S2 = 4;
    localparam int STRIDE_S3 = 1;

    localparam int SEL_LSB_S1 = 4;
    localparam int SEL_LSB_S2 = 2;
    localparam int SEL_LSB_S3 = 0;

    // op[1] selects the 32-bit word form.
    function automatic logic op_is_word(input logic [1:0] op);
        return op[1];
    endfunction

    // op[0] selects an arithmetic (sign-filling) shift.
    function automatic logic op_is_arith(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/srl_stage.sv
// srl_stage: one registered radix-4 right-shift step.
//   - Shifts up_data right by STRIDE * up_shamt[SEL_LSB+:2].
//   - Vacated top bits are filled with up_fill.
//   - The result is captured, together with the sideband, into a single register slice.
// Ports:
//   clk, rst_n, flush                       clock, async active-low reset, sync kill
//   up_valid/up_ready                       upstream handshake
//   up_data/up_shamt/up_fill/up_word/up_tag upstream payload
//   dn_valid/dn_ready                       downstream handshake
//   dn_data/dn_shamt/dn_fill/dn_word/dn_tag registered payload
module srl_stage
    import shift_pkg::*;
#(
    parameter int STRIDE  = 1,
    parameter int SEL_LSB = 0,
    parameter int TAG_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               up_valid,
    output logic               up_ready,
    input  logic [XLEN-1:0]    up_data,
    input  logic [SHAMT_W-1:0] up_shamt,
    input  logic               up_fill,
    input  logic               up_word,
    input  logic [TAG_W-1:0]   up_tag,
    output logic               dn_valid,
    input  logic               dn_ready,
    output logic [XLEN-1:0]    dn_data,
    output logic [SHAMT_W-1:0] dn_shamt,
    output logic               dn_fill,
    output logic               dn_word,
    output logic [TAG_W-1:0]   dn_tag
);

    localparam int SH1 = STRIDE;
    localparam int SH2 = 2 * STRIDE;
    localparam int SH3 = 3 * STRIDE;

    logic [1:0]         sel;
    logic [XLEN-1:0]    shifted;
    logic               load;

    logic               valid_q, valid_d;
    logic [XLEN-1:0]    data_q, data_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic               fill_q, fill_d;
    logic               word_q, word_d;
    logic [TAG_W-1:0]   tag_q, tag_d;

    always_comb begin
        sel     = up_shamt[SEL_LSB +: 2];
        shifted = up_data;
        case (sel)
            2'd0: shifted = up_data;
            2'd1: shifted = {{SH1{up_fill}}, up_data[XLEN-1:SH1]};
            2'd2: shifted = {{SH2{up_fill}}, up_data[XLEN-1:SH2]};
            2'd3: shifted = {{SH3{up_fill}}, up_data[XLEN-1:SH3]};
            default: shifted = up_data;
        endcase
    end

    // Handshake: a beat moves across a boundary only on a cycle where valid
    // and ready are both high. This slice is ready when it is empty or when its
    // own content leaves downstream in the same cycle, so a bubble is
    // collapsed while later stages stall. A stalled slice keeps its payload
    // untouched. flush empties the slice and wins over any transfer that cycle.
    assign up_ready = !valid_q || dn_ready;
    assign load     = up_valid && up_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        fill_d  = fill_q;
        word_d  = word_q;
        tag_d   = tag_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (up_ready) begin
            valid_d = up_valid;
        end
        if (load) begin
            data_d  = shifted;
            shamt_d = up_shamt;
            fill_d  = up_fill;
            word_d  = up_word;
            tag_d   = up_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            fill_q  <= 1'b0;
            word_q  <= 1'b0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            fill_q  <= fill_d;
            word_q  <= word_d;
            tag_q   <= tag_d;
        end
    end

    assign dn_valid = valid_q;
    assign dn_data  = data_q;
    assign dn_shamt = shamt_q;
    assign dn_fill  = fill_q;
    assign dn_word  = word_q;
    assign dn_tag   = tag_q;

endmodule

// File: rtl/srl64_pipe.sv
// srl64_pipe: three-stage pipelined RV64 right shifter (SRL, SRA, SRLW, SRAW).
//   - Input preparation builds the fill bit, the word operand and the effective shamt.
//   - Three srl_stage slices shift by 16/4/1 x two shamt bits each.
//   - Word results are sign-extended from bit 31 at the output.
// Ports:
//   clk, rst_n, flush            clock, async active-low reset, sync kill
//   in_valid/in_ready            input handshake (in_ready follows out_ready through the stages)
//   in_x, in_shamt, in_op, in_tag
//                                operand, shift count, operation, pass-through tag
//   out_valid/out_ready          output handshake
//   out_y, out_tag               result and its tag
module srl64_pipe
    import shift_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_x,
    input  logic [5:0]       in_shamt,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_y,
    output logic [TAG_W-1:0] out_tag
);

    logic               prep_word;
    logic               prep_fill;
    logic [XLEN-1:0]    prep_data;
    logic [SHAMT_W-1:0] prep_shamt;

    // Word ops pre-fill the upper half so the 64-bit stages produce the right
    // low word; shamt[5] is dropped because word shifts only go up to 31.
    always_comb begin
        prep_word  = op_is_word(in_op);
        prep_fill  = op_is_arith(in_op) & (prep_word ? in_x[31] : in_x[63]);
        prep_data  = prep_word ? {{32{prep_fill}}, in_x[31:0]} : in_x;
        prep_shamt = prep_word ? {1'b0, in_shamt[4:0]} : in_shamt;
    end

    logic               s1_valid, s1_ready;
    logic [XLEN-1:0]    s1_data;
    logic [SHAMT_W-1:0] s1_shamt;
    logic               s1_fill, s1_word;
    logic [TAG_W-1:0]   s1_tag;

    logic               s2_valid, s2_ready;
    logic [XLEN-1:0]    s2_data;
    logic [SHAMT_W-1:0] s2_shamt;
    logic               s2_fill, s2_word;
    logic [TAG_W-1:0]   s2_tag;

    logic               s3_valid;
    logic [XLEN-1:0]    s3_data;
    logic [SHAMT_W-1:0] s3_shamt;
    logic               s3_fill, s3_word;
    logic [TAG_W-1:0]   s3_tag;

    srl_stage #(.STRIDE(STRIDE_S1), .SEL_LSB(SEL_LSB_S1), .TAG_W(TAG_W)) u_stage1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .up_valid (in_valid),
        .up_ready (in_ready),
        .up_data  (prep_data),
        .up_shamt (prep_shamt),
        .up_fill  (prep_fill),
        .up_word  (prep_word),
        .up_tag   (in_tag),
        .dn_valid (s1_valid),
        .dn_ready (s1_ready),
        .dn_data  (s1_data),
        .dn_shamt (s1_shamt),
        .dn_fill  (s1_fill),
        .dn_word  (s1_word),
        .dn_tag   (s1_tag)
    );

    srl_stage #(.STRIDE(STRIDE_S2), .SEL_LSB(SEL_LSB_S2), .TAG_W(TAG_W)) u_stage2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .up_valid (s1_valid),
        .up_ready (s1_ready),
        .up_data  (s1_data),
        .up_shamt (s1_shamt),
        .up_fill  (s1_fill),
        .up_word  (s1_word),
        .up_tag   (s1_tag),
        .dn_valid (s2_valid),
        .dn_ready (s2_ready),
        .dn_data  (s2_data),
        .dn_shamt (s2_shamt),
        .dn_fill  (s2_fill),
        .dn_word  (s2_word),
        .dn_tag   (s2_tag)
    );

    srl_stage #(.STRIDE(STRIDE_S3), .SEL_LSB(SEL_LSB_S3), .TAG_W(TAG_W)) u_stage3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .up_valid (s2_valid),
        .up_ready (s2_ready),
        .up_data  (s2_data),
        .up_shamt (s2_shamt),
        .up_fill  (s2_fill),
        .up_word  (s2_word),
        .up_tag   (s2_tag),
        .dn_valid (s3_valid),
        .dn_ready (out_ready),
        .dn_data  (s3_data),
        .dn_shamt (s3_shamt),
        .dn_fill  (s3_fill),
        .dn_word  (s3_word),
        .dn_tag   (s3_tag)
    );

    // The last slice's shamt and fill have no consumer past the shifter.
    logic unused_s3;
    assign unused_s3 = ^{s3_shamt, s3_fill};

    // SRLW also sign-extends its 32-bit result (RV64 W-op rule).
    assign out_y     = s3_word ? {{32{s3_data[31]}}, s3_data[31:0]} : s3_data;
    assign out_valid = s3_valid;
    assign out_tag   = s3_tag;

endmodule

// File: tb/tb_srl64_pipe.sv
module tb_srl64_pipe;

    localparam int TAG_W = 5;
    localparam int EW    = 64 + TAG_W;

    localparam logic [1:0] OP_SRL  = 2'b00;
    localparam logic [1:0] OP_SRA  = 2'b01;
    localparam logic [1:0] OP_SRLW = 2'b10;
    localparam logic [1:0] OP_SRAW = 2'b11;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_x;
    logic [5:0]       in_shamt;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_y;
    logic [TAG_W-1:0] out_tag;

    srl64_pipe #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_tag   (out_tag)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0]    exp_q[$];
    int               n_vec = 0;
    int               n_err = 0;
    logic [TAG_W-1:0] next_tag = '0;
    logic             hold_chk = 1'b0;
    logic [EW-1:0]    hold_val;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: RV64 shift semantics in plain arithmetic.
    function automatic logic [63:0] ref_shift(input logic [63:0] x, input logic [5:0] sh,
                                              input logic [1:0] op);
        logic signed [63:0] xs;
        logic signed [31:0] ws;
        logic [31:0]        w;
        xs = x;
        ws = x[31:0];
        case (op)
            OP_SRL:  return x >> sh;
            OP_SRA:  return xs >>> sh;
            OP_SRLW: begin
                w = x[31:0] >> sh[4:0];
                return {{32{w[31]}}, w};
            end
            default: begin
                w = ws >>> sh[4:0];
                return {{32{w[31]}}, w};
            end
        endcase
    endfunction

    // Output monitor: in-order comparison of every accepted result and
    // stability of a stalled result.
    always @(negedge clk) begin
        if (rst_n && !flush) begin
            if (hold_chk && out_valid)
                check("stall_hold", {out_tag, out_y}, hold_val);
            hold_chk = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {out_tag, out_y}, 128'hDEAD);
                end else begin
                    check("result", {out_tag, out_y}, exp_q.pop_front());
                end
            end else if (out_valid) begin
                hold_chk = 1'b1;
                hold_val = {out_tag, out_y};
            end
        end else begin
            hold_chk = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [63:0] x, input logic [5:0] sh, input logic [1:0] op,
                        input logic [63:0] y);
        logic done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_x     = x;
        in_shamt = sh;
        in_op    = op;
        in_tag   = next_tag;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({next_tag, y});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (done) break;
        end
        in_valid = 1'b0;
        next_tag = next_tag + 1'b1;
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic send_ref(input logic [63:0] x, input logic [5:0] sh, input logic [1:0] op);
        send(x, sh, op, ref_shift(x, sh, op));
    endtask

    task automatic drain();
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [63:0] x;
        logic [5:0]  sh;
        logic [1:0]  op;
        logic [63:0] y;
    } vec_t;

    vec_t tbl[12];
    logic rnd_on;

    initial begin
        int lat;
        int k;
        logic [63:0] bx[6];
        logic [5:0]  bs[6];
        logic [1:0]  bo[6];

        tbl[0]  = '{64'h8000_0000_0000_00F0, 6'd4,  OP_SRL,  64'h0800_0000_0000_000F};
        tbl[1]  = '{64'h8000_0000_0000_00F0, 6'd4,  OP_SRA,  64'hF800_0000_0000_000F};
        tbl[2]  = '{64'h8000_0000_0000_00F0, 6'd63, OP_SRA,  64'hFFFF_FFFF_FFFF_FFFF};
        tbl[3]  = '{64'hDEAD_BEEF_8000_0000, 6'd0,  OP_SRLW, 64'hFFFF_FFFF_8000_0000};
        tbl[4]  = '{64'hDEAD_BEEF_8000_0000, 6'd1,  OP_SRLW, 64'h0000_0000_4000_0000};
        tbl[5]  = '{64'hDEAD_BEEF_8000_0000, 6'd33, OP_SRAW, 64'hFFFF_FFFF_C000_0000};
        tbl[6]  = '{64'h0123_4567_89AB_CDEF, 6'd0,  OP_SRL,  64'h0123_4567_89AB_CDEF};
        tbl[7]  = '{64'h8000_0000_0000_0000, 6'd63, OP_SRL,  64'h0000_0000_0000_0001};
        tbl[8]  = '{64'h0000_0000_8000_0001, 6'd32, OP_SRAW, 64'hFFFF_FFFF_8000_0001};
        tbl[9]  = '{64'h1234_5678_7FFF_FFF0, 6'd4,  OP_SRLW, 64'h0000_0000_07FF_FFFF};
        tbl[10] = '{64'h7000_0000_0000_0000, 6'd17, OP_SRA,  64'h0000_3800_0000_0000};
        tbl[11] = '{64'hFFFF_FFFF_FFFF_FFFF, 6'd37, OP_SRL,  64'h0000_0000_07FF_FFFF};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_shamt  = '0;
        in_op     = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        rnd_on    = 1'b0;

        // Reset state.
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_y", out_y, 0);
        check("rst_out_tag", out_tag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency of a lone op on an empty pipe.
        in_valid = 1'b1;
        in_x     = tbl[0].x;
        in_shamt = tbl[0].sh;
        in_op    = tbl[0].op;
        in_tag   = next_tag;
        @(negedge clk);
        check("lat_accept_ready", in_ready, 1);
        exp_q.push_back({next_tag, tbl[0].y});
        next_tag = next_tag + 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        check("latency", lat, 3);
        @(posedge clk);
        #1;
        drain();

        // Table of directed vectors, streamed back-to-back.
        for (int i = 0; i < 12; i++)
            send(tbl[i].x, tbl[i].sh, tbl[i].op, tbl[i].y);
        drain();

        // Stage-3 mapping: 1,2,3 on consecutive cycles with matching tags.
        k = int'(next_tag);
        send(64'h80, 6'd1, OP_SRL, 64'h40);
        send(64'h80, 6'd2, OP_SRL, 64'h20);
        send(64'h80, 6'd3, OP_SRL, 64'h10);
        @(negedge clk);
        for (int t = 0; t < 10 && !out_valid; t++) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("map_valid", out_valid, 1);
            check("map_y", out_y, 64'h80 >> (i + 1));
            check("map_tag", out_tag, TAG_W'(k + i));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        drain();

        // Backpressure: out_ready low for 5 cycles while ops are offered.
        for (int i = 0; i < 6; i++) begin
            bx[i] = {$urandom, $urandom};
            bs[i] = 6'($urandom_range(0, 63));
            bo[i] = 2'($urandom_range(0, 3));
        end
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_x     = bx[k];
            in_shamt = bs[k];
            in_op    = bo[k];
            in_tag   = next_tag;
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({next_tag, ref_shift(bx[k], bs[k], bo[k])});
                next_tag = next_tag + 1'b1;
                k++;
            end
            @(posedge clk);
            #1;
        end
        check("bp_accepts", k, 3);
        check("bp_in_ready_low", in_ready, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 3; i < 6; i++) send_ref(bx[i], bs[i], bo[i]);
        drain();

        // Flush with three in flight and one offered.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_ref({$urandom, $urandom}, 6'($urandom_range(0, 63)), OP_SRL);
        in_valid = 1'b1;
        in_x     = 64'hFFFF_0000_FFFF_0000;
        in_shamt = 6'd8;
        in_op    = OP_SRA;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        idle(6);
        check("flush_no_out", out_valid, 0);
        send(64'hFFFF_FFFF_FFFF_FFF0, 6'd2, OP_SRA, 64'hFFFF_FFFF_FFFF_FFFC);
        drain();

        // Reset mid-stream with two ops in flight.
        send_ref(64'h1111_2222_3333_4444, 6'd5, OP_SRL);
        send_ref(64'h8888_0000_0000_0001, 6'd9, OP_SRA);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_y", out_y, 0);
        check("mid_rst_in_ready", in_ready, 1);
        exp_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle(6);
        check("post_rst_no_out", out_valid, 0);

        // Random ops with random backpressure.
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 4) == 0) idle(1);
                    send_ref({$urandom, $urandom}, 6'($urandom_range(0, 63)),
                             2'($urandom_range(0, 3)));
                end
                rnd_on = 1'b0;
            end
        join
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
